uart_rx_framed: RTL and testbench
=================================

// Module: uart_rx_framed
// PURPOSE
//  Parametrised UART receiver. Configurable data width, parity and stop bits.
//  Adds an input synchroniser, false-start rejection and parity/framing checks.
//  A one-entry output holding register with a valid/ready handshake reports overrun.
//  Sits between the board RXD pin and the CPU's MMIO UART register block.
// PARAMETERS
//  CLK_HZ     24_000_000  core clock frequency (Hz)
//  BAUDRATE   9_600       line rate; BIT_CNT = CLK_HZ/BAUDRATE (must be >= 8), HALF = BIT_CNT/2
//  DATA_BITS  8           payload bits per frame, 5..8, LSB first
//  PARITY     0           0 = none, 1 = odd, 2 = even
//  STOP_BITS  1           1 or 2
// PORTS
//  clock          in   1          core clock, all logic on posedge
//  reset_n        in   1          asynchronous, active-low reset
//  rxd            in   1          raw serial line, idle high, asynchronous to clock
//  rx_valid       out  1          holding register full
//  rx_ready       in   1          consumer accepts the held frame when rx_valid & rx_ready
//  rx_data        out  DATA_BITS  received payload, bit 0 = first bit on the line
//  rx_parity_err  out  1          parity mismatch for the held frame (0 when PARITY = 0)
//  rx_frame_err   out  1          at least one stop-bit sample was 0 for the held frame
//  rx_overrun     out  1          one-cycle pulse: a completed frame was dropped
// BEHAVIOUR
//  - Reset: every output is 0; FSM = IDLE; synchroniser flops = 1; counters = 0.
//    Reset mid-frame abandons the frame and clears the holding register.
//  - rxd passes through a 2-flop synchroniser (flops reset to 1). All sampling uses the synchronised value rxs.
//  - 25-bit down-counter cnt. A sample event occurs when cnt == 0.
//  - FSM states: IDLE, START, DATA, PAR, STOP.
//    IDLE:  when rxs == 0, go to START with cnt = HALF-1.
//    START: at the sample event, rxs == 1 is a glitch: return to IDLE, no flags, no output.
//           Otherwise set cnt = BIT_CNT-1, bit index = 0, go to DATA.
//    DATA:  at each sample event, shift rxs into position [bit index]; set cnt = BIT_CNT-1.
//           After bit DATA_BITS-1, go to PAR if PARITY != 0, else go to STOP.
//    PAR:   at the sample event, parity_err = (^data ^ rxs) != (PARITY == 1); reload cnt; go to STOP.
//    STOP:  sample STOP_BITS times, BIT_CNT apart. frame_err = OR of (rxs == 0) over the samples.
//           At the last sample, go directly to IDLE without waiting for the end of the bit. The frame completes.
//  - Frame completion (one cycle, the cycle after the final stop-bit sample edge):
//    * Holding register empty, or (rx_valid & rx_ready) in that cycle: load data and both error flags,
//      and rx_valid = 1 the next cycle.
//    * Holding register full and not consumed: frame is dropped, held contents unchanged,
//      rx_overrun = 1 for exactly one cycle.
//  - Handshake: rx_valid & rx_ready at a clock edge empties the register (rx_valid = 0 the next cycle)
//    unless a completion loads it in the same cycle.
//    rx_data and the error flags are stable while rx_valid = 1.
//  - A frame with errors is still delivered. A break (line held low) yields data 0 with frame_err = 1.
//    After a break, IDLE waits for rxs to return to 1 before arming a new start.
//  - Latency: from the rxd falling edge to rx_valid = 1 is
//    2 (sync) + HALF + BIT_CNT*(DATA_BITS + P + STOP_BITS - 1) + BIT_CNT + 1 cycles, where P = (PARITY != 0). Tolerance +-1.
//  - Widths: payload is DATA_BITS wide. No unused upper bits are driven.
// TESTING (bench: CLK_HZ = 1_600_000, BAUDRATE = 100_000, so BIT_CNT = 16)
//  1. 8N1, send 0xA5, rx_ready = 1 -> rx_valid for 1 cycle at 155+-1 cycles after the edge, rx_data = 0xA5,
//     both error flags 0.
//  2. Drive rxd low for 4 cycles, then send 0x3C -> no output from the glitch, then 0x3C delivered cleanly.
//  3. PARITY = 2, send 0x07 with parity bit 0 -> rx_data = 0x07, rx_parity_err = 1.
//     With parity bit 1 -> rx_parity_err = 0.
//  4. DATA_BITS = 7, STOP_BITS = 2, send 0x55 with the second stop bit 0 -> rx_data = 7'h55, rx_frame_err = 1.
//     Hold rxd low for 20 bit times -> one frame with data 0 and frame_err = 1, then nothing until rxd rises.
//  5. rx_ready = 0, send 0x11 then 0x22 -> held value stays 0x11, rx_overrun pulses once at the 0x22 completion.
//     Raise rx_ready -> rx_valid drops. A completion coinciding with an accept loads the new byte, no overrun.
//  6. Assert reset_n = 0 during data bit 3 -> all outputs 0 immediately.
//     Release, then send 0x5A -> 0x5A received clean.

Source files
------------

// File: rtl/uart_rx_framed.sv
// UART receiver with input synchroniser, false-start rejection, parity/framing checks
// and a one-entry valid/ready holding register that flags overrun.
module uart_rx_framed #(
    parameter int unsigned CLK_HZ    = 24_000_000,
    parameter int unsigned BAUDRATE  = 9_600,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 rxd,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    localparam int unsigned BIT_CNT     = CLK_HZ / BAUDRATE;
    localparam int unsigned HALF        = BIT_CNT / 2;
    localparam logic [24:0] BIT_RELOAD  = 25'(BIT_CNT - 1);
    localparam logic [24:0] HALF_RELOAD = 25'(HALF - 1);
    localparam logic [2:0]  LAST_BIT    = 3'(DATA_BITS - 1);
    localparam logic        LAST_STOP   = (STOP_BITS == 2);

    typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_t;

    logic                 r_sync1, r_sync2;
    state_t               r_state, w_state_d;
    logic [24:0]          r_cnt, w_cnt_d;
    logic [2:0]           r_bit_idx, w_bit_idx_d;
    logic                 r_stop_idx, w_stop_idx_d;
    logic [DATA_BITS-1:0] r_shift, w_shift_d;
    logic                 r_par_err, w_par_err_d;
    logic                 r_frm_err, w_frm_err_d;
    logic                 r_armed, w_armed_d;
    logic                 r_done, w_done_d;
    logic                 r_valid, w_valid_d;
    logic [DATA_BITS-1:0] r_data, w_data_d;
    logic                 r_perr_hold, w_perr_hold_d;
    logic                 r_ferr_hold, w_ferr_hold_d;
    logic                 r_overrun, w_overrun_d;
    logic                 w_rxs, w_tick, w_accept;

    assign w_rxs    = r_sync2;
    assign w_tick   = (r_cnt == 25'd0);
    assign w_accept = r_valid & rx_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_stop_idx  <= 1'b0;
            r_shift     <= '0;
            r_par_err   <= 1'b0;
            r_frm_err   <= 1'b0;
            r_armed     <= 1'b0;
            r_done      <= 1'b0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_perr_hold <= 1'b0;
            r_ferr_hold <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync1     <= rxd;
            r_sync2     <= r_sync1;
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_bit_idx   <= w_bit_idx_d;
            r_stop_idx  <= w_stop_idx_d;
            r_shift     <= w_shift_d;
            r_par_err   <= w_par_err_d;
            r_frm_err   <= w_frm_err_d;
            r_armed     <= w_armed_d;
            r_done      <= w_done_d;
            r_valid     <= w_valid_d;
            r_data      <= w_data_d;
            r_perr_hold <= w_perr_hold_d;
            r_ferr_hold <= w_ferr_hold_d;
            r_overrun   <= w_overrun_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_bit_idx_d  = r_bit_idx;
        w_stop_idx_d = r_stop_idx;
        w_shift_d    = r_shift;
        w_par_err_d  = r_par_err;
        w_frm_err_d  = r_frm_err;
        w_armed_d    = r_armed;
        w_done_d     = 1'b0;
        if (r_state != StIdle && !w_tick) begin
            w_cnt_d = r_cnt - 25'd1;
        end
        unique case (r_state)
            StIdle: begin
                // A start is only armed once the line has been seen high (post-break recovery).
                if (w_rxs) begin
                    w_armed_d = 1'b1;
                end else if (r_armed) begin
                    w_state_d = StStart;
                    w_cnt_d   = HALF_RELOAD;
                end
            end
            StStart: begin
                if (w_tick) begin
                    if (w_rxs) begin
                        w_state_d = StIdle;
                    end else begin
                        w_state_d    = StData;
                        w_cnt_d      = BIT_RELOAD;
                        w_bit_idx_d  = '0;
                        w_stop_idx_d = 1'b0;
                        w_par_err_d  = 1'b0;
                        w_frm_err_d  = 1'b0;
                    end
                end
            end
            StData: begin
                if (w_tick) begin
                    // LSB first: after DATA_BITS right-shifts the first bit sits at bit 0.
                    w_shift_d   = {w_rxs, r_shift[DATA_BITS-1:1]};
                    w_cnt_d     = BIT_RELOAD;
                    w_bit_idx_d = r_bit_idx + 3'd1;
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_d = (PARITY != 0) ? StPar : StStop;
                    end
                end
            end
            StPar: begin
                if (w_tick) begin
                    w_par_err_d = ((^r_shift) ^ w_rxs) != (PARITY == 1);
                    w_cnt_d     = BIT_RELOAD;
                    w_state_d   = StStop;
                end
            end
            StStop: begin
                if (w_tick) begin
                    w_frm_err_d = r_frm_err | ~w_rxs;
                    if (r_stop_idx == LAST_STOP) begin
                        w_state_d = StIdle;
                        w_done_d  = 1'b1;
                        w_armed_d = w_rxs;
                    end else begin
                        w_stop_idx_d = 1'b1;
                        w_cnt_d      = BIT_RELOAD;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_valid_d     = r_valid;
        w_data_d      = r_data;
        w_perr_hold_d = r_perr_hold;
        w_ferr_hold_d = r_ferr_hold;
        w_overrun_d   = 1'b0;
        if (r_done) begin
            if (!r_valid || w_accept) begin
                w_valid_d     = 1'b1;
                w_data_d      = r_shift;
                w_perr_hold_d = r_par_err;
                w_ferr_hold_d = r_frm_err;
            end else begin
                w_overrun_d = 1'b1;
            end
        end else if (w_accept) begin
            w_valid_d = 1'b0;
        end
    end

    assign rx_valid      = r_valid;
    assign rx_data       = r_data;
    assign rx_parity_err = r_perr_hold;
    assign rx_frame_err  = r_ferr_hold;
    assign rx_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed: three instances (8N1, 8E1, 7N2) at 16 clocks per bit.
module tb_uart_rx_framed;

    logic clk;
    logic reset_n;

    logic       rxd_a, ready_a, valid_a, perr_a, ferr_a, ovr_a;
    logic [7:0] data_a;
    logic       rxd_b, ready_b, valid_b, perr_b, ferr_b, ovr_b;
    logic [7:0] data_b;
    logic       rxd_c, ready_c, valid_c, perr_c, ferr_c, ovr_c;
    logic [6:0] data_c;

    int n_tests = 0;
    int n_fail  = 0;

    // Monitors sampled on the falling edge; tasks read them #1 after a rising edge.
    int          cyc = 0;
    int          acc_a = 0, acc_b = 0, acc_c = 0;
    int          vhi_a = 0, ovr_cnt_a = 0, rise_a = 0;
    logic        prev_valid_a = 1'b0;
    logic [7:0]  last_data_a = '0, last_data_b = '0;
    logic [6:0]  last_data_c = '0;
    logic        last_perr_a = 0, last_ferr_a = 0, last_perr_b = 0, last_ferr_b = 0;
    logic        last_perr_c = 0, last_ferr_c = 0;

    uart_rx_framed #(
        .CLK_HZ(1_600_000), .BAUDRATE(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) u_dut_8n1 (
        .clock(clk), .reset_n(reset_n), .rxd(rxd_a), .rx_valid(valid_a), .rx_ready(ready_a),
        .rx_data(data_a), .rx_parity_err(perr_a), .rx_frame_err(ferr_a), .rx_overrun(ovr_a)
    );

    uart_rx_framed #(
        .CLK_HZ(1_600_000), .BAUDRATE(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
    ) u_dut_8e1 (
        .clock(clk), .reset_n(reset_n), .rxd(rxd_b), .rx_valid(valid_b), .rx_ready(ready_b),
        .rx_data(data_b), .rx_parity_err(perr_b), .rx_frame_err(ferr_b), .rx_overrun(ovr_b)
    );

    uart_rx_framed #(
        .CLK_HZ(1_600_000), .BAUDRATE(100_000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)
    ) u_dut_7n2 (
        .clock(clk), .reset_n(reset_n), .rxd(rxd_c), .rx_valid(valid_c), .rx_ready(ready_c),
        .rx_data(data_c), .rx_parity_err(perr_c), .rx_frame_err(ferr_c), .rx_overrun(ovr_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_valid_a <= valid_a;
        if (valid_a && !prev_valid_a) rise_a <= cyc;
        if (valid_a) vhi_a <= vhi_a + 1;
        if (ovr_a) ovr_cnt_a <= ovr_cnt_a + 1;
        if (valid_a && ready_a) begin
            acc_a       <= acc_a + 1;
            last_data_a <= data_a;
            last_perr_a <= perr_a;
            last_ferr_a <= ferr_a;
        end
        if (valid_b && ready_b) begin
            acc_b       <= acc_b + 1;
            last_data_b <= data_b;
            last_perr_b <= perr_b;
            last_ferr_b <= ferr_b;
        end
        if (valid_c && ready_c) begin
            acc_c       <= acc_c + 1;
            last_data_c <= data_c;
            last_perr_c <= perr_c;
            last_ferr_c <= ferr_c;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives n line bits (bit 0 first), 16 clocks each, on the selected instance.
    task automatic drive_bits(input int which, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            case (which)
                0:       rxd_a = bits[i];
                1:       rxd_b = bits[i];
                default: rxd_c = bits[i];
            endcase
            wait_cycles(16);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        wait_cycles(3);
        n_tests++;
        if ({valid_a, data_a, perr_a, ferr_a, ovr_a} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_8n1: got %h expected 000", {valid_a, data_a, perr_a, ferr_a, ovr_a});
        end
        n_tests++;
        if ({valid_b, data_b, perr_b, ferr_b, ovr_b} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_8e1: got %h expected 000", {valid_b, data_b, perr_b, ferr_b, ovr_b});
        end
        n_tests++;
        if ({valid_c, data_c, perr_c, ferr_c, ovr_c} !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_7n2: got %h expected 000", {valid_c, data_c, perr_c, ferr_c, ovr_c});
        end
        reset_n = 1'b1;
        wait_cycles(10);
    endtask

    task automatic test_basic;
        int a0, v0, t0, lat;
        ready_a = 1'b1;
        a0 = acc_a; v0 = vhi_a;
        t0 = cyc;
        drive_bits(0, {1'b1, 8'hA5, 1'b0}, 10);
        wait_cycles(10);
        // Latency counted from the first rising edge that can see the low line.
        lat = rise_a - t0 - 1;
        n_tests++;
        if (lat < 154 || lat > 156) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d expected 155+-1", lat);
        end
        n_tests++;
        if (acc_a - a0 != 1) begin
            n_fail++;
            $display("FAIL basic_count: got %0d expected 1", acc_a - a0);
        end
        n_tests++;
        if (vhi_a - v0 != 1) begin
            n_fail++;
            $display("FAIL basic_valid_cycles: got %0d expected 1", vhi_a - v0);
        end
        n_tests++;
        if (last_data_a !== 8'hA5) begin
            n_fail++;
            $display("FAIL basic_data: got %h expected a5", last_data_a);
        end
        n_tests++;
        if ({last_perr_a, last_ferr_a} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_flags: got %b expected 00", {last_perr_a, last_ferr_a});
        end
    endtask

    task automatic test_glitch;
        int a0, v0;
        a0 = acc_a; v0 = vhi_a;
        rxd_a = 1'b0;
        wait_cycles(4);
        rxd_a = 1'b1;
        wait_cycles(40);
        n_tests++;
        if (vhi_a - v0 != 0) begin
            n_fail++;
            $display("FAIL glitch_no_output: got %0d valid cycles expected 0", vhi_a - v0);
        end
        drive_bits(0, {1'b1, 8'h3C, 1'b0}, 10);
        wait_cycles(10);
        n_tests++;
        if (acc_a - a0 != 1) begin
            n_fail++;
            $display("FAIL glitch_count: got %0d expected 1", acc_a - a0);
        end
        n_tests++;
        if ({last_data_a, last_perr_a, last_ferr_a} !== {8'h3C, 2'b00}) begin
            n_fail++;
            $display("FAIL glitch_frame: got %h expected %h",
                     {last_data_a, last_perr_a, last_ferr_a}, {8'h3C, 2'b00});
        end
    endtask

    task automatic test_parity;
        int b0;
        ready_b = 1'b1;
        b0 = acc_b;
        // 0x07 has three ones: even parity bit must be 1.
        drive_bits(1, {1'b1, 1'b0, 8'h07, 1'b0}, 11);
        wait_cycles(10);
        n_tests++;
        if ({last_data_b, last_perr_b, last_ferr_b} !== {8'h07, 2'b10}) begin
            n_fail++;
            $display("FAIL parity_bad: got %h expected %h",
                     {last_data_b, last_perr_b, last_ferr_b}, {8'h07, 2'b10});
        end
        drive_bits(1, {1'b1, 1'b1, 8'h07, 1'b0}, 11);
        wait_cycles(10);
        n_tests++;
        if ({last_data_b, last_perr_b, last_ferr_b} !== {8'h07, 2'b00}) begin
            n_fail++;
            $display("FAIL parity_good: got %h expected %h",
                     {last_data_b, last_perr_b, last_ferr_b}, {8'h07, 2'b00});
        end
        n_tests++;
        if (acc_b - b0 != 2) begin
            n_fail++;
            $display("FAIL parity_count: got %0d expected 2", acc_b - b0);
        end
    endtask

    task automatic test_framing;
        int c0;
        ready_c = 1'b1;
        c0 = acc_c;
        drive_bits(2, {1'b0, 1'b1, 7'h55, 1'b0}, 10);
        rxd_c = 1'b1;
        wait_cycles(30);
        n_tests++;
        if ({last_data_c, last_perr_c, last_ferr_c} !== {7'h55, 2'b01} || acc_c - c0 != 1) begin
            n_fail++;
            $display("FAIL frame_stop2: got %h/%0d expected %h/1",
                     {last_data_c, last_perr_c, last_ferr_c}, acc_c - c0, {7'h55, 2'b01});
        end
        c0 = acc_c;
        rxd_c = 1'b0;
        wait_cycles(20 * 16);
        n_tests++;
        if (acc_c - c0 != 1) begin
            n_fail++;
            $display("FAIL break_count: got %0d expected 1", acc_c - c0);
        end
        n_tests++;
        if ({last_data_c, last_ferr_c} !== {7'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL break_frame: got %h expected %h", {last_data_c, last_ferr_c}, 8'h01);
        end
        rxd_c = 1'b1;
        wait_cycles(60);
        n_tests++;
        if (acc_c - c0 != 1) begin
            n_fail++;
            $display("FAIL break_recover: got %0d frames expected 1", acc_c - c0);
        end
    endtask

    task automatic test_overrun;
        int o0, a0;
        ready_a = 1'b0;
        o0 = ovr_cnt_a;
        drive_bits(0, {1'b1, 8'h11, 1'b0}, 10);
        drive_bits(0, {1'b1, 8'h22, 1'b0}, 10);
        wait_cycles(5);
        n_tests++;
        if (ovr_cnt_a - o0 != 1) begin
            n_fail++;
            $display("FAIL overrun_pulse: got %0d cycles expected 1", ovr_cnt_a - o0);
        end
        n_tests++;
        if ({valid_a, data_a} !== {1'b1, 8'h11}) begin
            n_fail++;
            $display("FAIL overrun_hold: got %h expected %h", {valid_a, data_a}, {1'b1, 8'h11});
        end
        ready_a = 1'b1;
        wait_cycles(1);
        ready_a = 1'b0;
        n_tests++;
        if (valid_a !== 1'b0 || last_data_a !== 8'h11) begin
            n_fail++;
            $display("FAIL accept_drop: got valid %b data %h expected 0 11", valid_a, last_data_a);
        end
        drive_bits(0, {1'b1, 8'h33, 1'b0}, 10);
        wait_cycles(5);
        o0 = ovr_cnt_a; a0 = acc_a;
        // Completion of the next frame lands in the cycle after edge 155; accept exactly at 156.
        fork
            drive_bits(0, {1'b1, 8'h44, 1'b0}, 10);
            begin
                wait_cycles(155);
                ready_a = 1'b1;
                wait_cycles(1);
                ready_a = 1'b0;
            end
        join
        wait_cycles(5);
        n_tests++;
        if (ovr_cnt_a - o0 != 0) begin
            n_fail++;
            $display("FAIL coincide_overrun: got %0d expected 0", ovr_cnt_a - o0);
        end
        n_tests++;
        if (acc_a - a0 != 1 || last_data_a !== 8'h33) begin
            n_fail++;
            $display("FAIL coincide_accept: got %0d/%h expected 1/33", acc_a - a0, last_data_a);
        end
        n_tests++;
        if ({valid_a, data_a} !== {1'b1, 8'h44}) begin
            n_fail++;
            $display("FAIL coincide_load: got %h expected %h", {valid_a, data_a}, {1'b1, 8'h44});
        end
    endtask

    task automatic test_midframe_reset;
        int a0;
        // Start, bits 0..2 of 0x5A, then half of bit 3, with 0x44 still held.
        drive_bits(0, {8'h5A, 1'b0}, 4);
        rxd_a = 1'b1;
        wait_cycles(8);
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({valid_a, data_a, perr_a, ferr_a, ovr_a} !== 12'h000) begin
            n_fail++;
            $display("FAIL midframe_reset: got %h expected 000",
                     {valid_a, data_a, perr_a, ferr_a, ovr_a});
        end
        wait_cycles(4);
        reset_n = 1'b1;
        wait_cycles(20);
        ready_a = 1'b1;
        a0 = acc_a;
        drive_bits(0, {1'b1, 8'h5A, 1'b0}, 10);
        wait_cycles(10);
        n_tests++;
        if (acc_a - a0 != 1 || {last_data_a, last_perr_a, last_ferr_a} !== {8'h5A, 2'b00}) begin
            n_fail++;
            $display("FAIL after_reset: got %0d/%h expected 1/%h", acc_a - a0,
                     {last_data_a, last_perr_a, last_ferr_a}, {8'h5A, 2'b00});
        end
    endtask

    initial begin
        reset_n = 1'b0;
        rxd_a = 1'b1; rxd_b = 1'b1; rxd_c = 1'b1;
        ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_glitch();
        test_parity();
        test_framing();
        test_overrun();
        test_midframe_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
